// File: rtl/alu_rr_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// alu_rr_sequencer_pkg
//   Shared definitions for the ALU round-robin sequencer slice.
//   Contents:
//     DEFAULT_W / DEFAULT_CNT_W : default operand and counter widths
//     P0 / P1                   : requester port indices
//     state_e                   : sequencer FSM encoding (IDLE, EXEC, DONE)
//     carryOut()                : unsigned carry-out recovered from operand
//                                 MSBs and the sum MSB
//     portMask()                : one-hot 2-bit mask for a port index
// ---------------------------------------------------------------------------
package alu_rr_sequencer_pkg;

  localparam int DEFAULT_W     = 8;
  localparam int DEFAULT_CNT_W = 16;

  localparam int P0 = 0;
  localparam int P1 = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  // The shared ALU only exposes an 8-bit F, so the carry-out is rebuilt from
  // the two operand MSBs and the result MSB: a carry leaves the top bit when
  // both MSBs are set, or when exactly one is set and the sum MSB came out 0.
  function automatic logic carryOut(input logic aMsb,
                                    input logic bMsb,
                                    input logic fMsb);
    return (aMsb & bMsb) | ((aMsb | bMsb) & ~fMsb);
  endfunction

  function automatic logic [1:0] portMask(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu_rr_sequencer_arb.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
//   Two-input round-robin arbiter. Picks a winner combinationally from the
//   current request vector and keeps the priority pointer, which names the
//   preferred port when both ports request at once.
//   Ports:
//     clk_i      : system clock
//     rst_ni     : asynchronous active-low reset (pointer returns to port 0)
//     req_i      : request vector, bit n = port n
//     advance_i  : a grant is being issued this cycle; move the pointer
//     winner_o   : index of the selected port (meaningful when req_i != 0)
// ---------------------------------------------------------------------------
module rr_arbiter2
  import alu_rr_sequencer_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic       winner_o
);

  logic ptr_q;
  logic ptr_d;

  // A lone requester always wins; the pointer only breaks ties.
  always_comb begin
    winner_o = ptr_q;
    case (req_i)
      2'b01:   winner_o = 1'(P0);
      2'b10:   winner_o = 1'(P1);
      default: winner_o = ptr_q;
    endcase
  end

  // After every grant the loser becomes the preferred port, so two ports
  // that keep requesting are served strictly alternately.
  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) begin
      ptr_d = ~winner_o;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= 1'(P0);
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/alu_rr_sequencer.sv
// ---------------------------------------------------------------------------
// alu_rr_sequencer
//   Shares one external W-bit adder ALU between two requesters. A request is
//   granted round-robin, the winner's operands are registered onto the ALU
//   inputs with ALUop raised for a single cycle, the ALU sum is captured
//   together with a derived carry-out, and a done pulse returns the result.
//   One operation takes three cycles: IDLE (grant) -> EXEC -> DONE.
//   Ports:
//     clk_i, rst_ni          : clock, asynchronous active-low reset
//     req_i[1:0]             : level requests, held until that port's done
//     opa0_i/opb0_i          : port-0 operands
//     opa1_i/opb1_i          : port-1 operands
//     gnt_o[1:0]             : one-hot pulse, operands of that port latched
//     done_o[1:0]            : one-hot pulse, result_o/carry_o valid
//     result_o, carry_o      : last captured sum and unsigned carry-out
//     busy_o                 : high whenever the sequencer is not IDLE
//     alu_a_o/alu_b_o/alu_op_o : drive ALU A, B and ALUop
//     alu_f_i                : ALU F, only trusted while alu_op_o is high
//     cnt0_o/cnt1_o          : completed operations per port (wrapping)
// ---------------------------------------------------------------------------
module alu_rr_sequencer
  import alu_rr_sequencer_pkg::*;
#(
  parameter int W     = DEFAULT_W,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [1:0]       req_i,
  input  logic [W-1:0]     opa0_i,
  input  logic [W-1:0]     opb0_i,
  input  logic [W-1:0]     opa1_i,
  input  logic [W-1:0]     opb1_i,
  output logic [1:0]       gnt_o,
  output logic [1:0]       done_o,
  output logic [W-1:0]     result_o,
  output logic             carry_o,
  output logic             busy_o,
  output logic [W-1:0]     alu_a_o,
  output logic [W-1:0]     alu_b_o,
  output logic             alu_op_o,
  input  logic [W-1:0]     alu_f_i,
  output logic [CNT_W-1:0] cnt0_o,
  output logic [CNT_W-1:0] cnt1_o
);

  state_e           state_q,  state_d;
  logic             winner_q, winner_d;
  logic [1:0]       gnt_q,    gnt_d;
  logic [1:0]       done_q,   done_d;
  logic [W-1:0]     result_q, result_d;
  logic             carry_q,  carry_d;
  logic             busy_q,   busy_d;
  logic [W-1:0]     aluA_q,   aluA_d;
  logic [W-1:0]     aluB_q,   aluB_d;
  logic             aluOp_q,  aluOp_d;
  logic [CNT_W-1:0] cnt0_q,   cnt0_d;
  logic [CNT_W-1:0] cnt1_q,   cnt1_d;

  logic             arbWinner;
  logic             grantEn;

  rr_arbiter2 u_arb (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (req_i),
    .advance_i (grantEn),
    .winner_o  (arbWinner)
  );

  // Next-state and next-output logic. Pulse outputs (gnt, done, alu_op)
  // default to 0 so they last exactly one cycle; data outputs default to
  // holding so result/carry and the ALU operands stay put between captures.
  // Requests are only looked at in IDLE, so anything req_i does during
  // EXEC or DONE cannot disturb the operation in flight.
  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    gnt_d    = 2'b00;
    done_d   = 2'b00;
    result_d = result_q;
    carry_d  = carry_q;
    aluA_d   = aluA_q;
    aluB_d   = aluB_q;
    aluOp_d  = 1'b0;
    cnt0_d   = cnt0_q;
    cnt1_d   = cnt1_q;
    grantEn  = 1'b0;

    case (state_q)
      IDLE: begin
        if (|req_i) begin
          grantEn  = 1'b1;
          winner_d = arbWinner;
          gnt_d    = portMask(arbWinner);
          aluA_d   = (arbWinner == 1'(P1)) ? opa1_i : opa0_i;
          aluB_d   = (arbWinner == 1'(P1)) ? opb1_i : opb0_i;
          aluOp_d  = 1'b1;
          state_d  = EXEC;
        end
      end

      // F is valid now because ALUop has been high for this whole cycle.
      EXEC: begin
        result_d = alu_f_i;
        carry_d  = carryOut(aluA_q[W-1], aluB_q[W-1], alu_f_i[W-1]);
        done_d   = portMask(winner_q);
        if (winner_q == 1'(P1)) begin
          cnt1_d = cnt1_q + CNT_W'(1);
        end else begin
          cnt0_d = cnt0_q + CNT_W'(1);
        end
        state_d = DONE;
      end

      // Dead cycle while done is visible; this gives the requester time to
      // drop its request before IDLE looks at req_i again.
      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers. Reset aborts any operation in flight, so a
  // grant that was already issued never produces a done pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      winner_q <= 1'(P0);
      gnt_q    <= 2'b00;
      done_q   <= 2'b00;
      result_q <= '0;
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
      aluA_q   <= '0;
      aluB_q   <= '0;
      aluOp_q  <= 1'b0;
      cnt0_q   <= '0;
      cnt1_q   <= '0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      busy_q   <= busy_d;
      aluA_q   <= aluA_d;
      aluB_q   <= aluB_d;
      aluOp_q  <= aluOp_d;
      cnt0_q   <= cnt0_d;
      cnt1_q   <= cnt1_d;
    end
  end

  assign gnt_o    = gnt_q;
  assign done_o   = done_q;
  assign result_o = result_q;
  assign carry_o  = carry_q;
  assign busy_o   = busy_q;
  assign alu_a_o  = aluA_q;
  assign alu_b_o  = aluB_q;
  assign alu_op_o = aluOp_q;
  assign cnt0_o   = cnt0_q;
  assign cnt1_o   = cnt1_q;

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_rr_sequencer
//   Drives two requesters against alu_rr_sequencer with a behavioural adder
//   ALU attached. Drivers push the operands of every request into a per-port
//   queue; an independent monitor predicts the arbitration winner from the
//   round-robin rule and the requests it saw, and checks grants, operands,
//   result, carry and counters whenever the sequencer presents them.
// ---------------------------------------------------------------------------
module tb_alu_rr_sequencer;

  localparam int W     = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0, req1;
  logic [1:0]       req;
  logic [W-1:0]     opa0, opb0, opa1, opb1;
  logic [1:0]       gnt, done;
  logic [W-1:0]     result;
  logic             carry, busy;
  logic [W-1:0]     aluA, aluB;
  logic             aluOp;
  logic [W-1:0]     aluF = '0;
  logic [CNT_W-1:0] cnt0, cnt1;

  int assertCount = 0;
  int failCount   = 0;

  logic [2*W-1:0] qa0[$];
  logic [2*W-1:0] qa1[$];

  assign req = {req1, req0};

  always #5 clk = ~clk;

  // Adder ALU that keeps its last F while ALUop is low.
  always @(aluA or aluB or aluOp) begin
    if (aluOp) aluF = aluA + aluB;
  end

  alu_rr_sequencer #(.W(W), .CNT_W(CNT_W)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .req_i    (req),
    .opa0_i   (opa0),
    .opb0_i   (opb0),
    .opa1_i   (opa1),
    .opb1_i   (opb1),
    .gnt_o    (gnt),
    .done_o   (done),
    .result_o (result),
    .carry_o  (carry),
    .busy_o   (busy),
    .alu_a_o  (aluA),
    .alu_b_o  (aluB),
    .alu_op_o (aluOp),
    .alu_f_i  (aluF),
    .cnt0_o   (cnt0),
    .cnt1_o   (cnt1)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic reportFail(input string name);
    assertCount++;
    failCount++;
    $display("[TB] FAIL %s: event did not occur as required at %0t", name, $time);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_gnt"},    32'(gnt),    0);
    checkOutput({tag, "_done"},   32'(done),   0);
    checkOutput({tag, "_result"}, 32'(result), 0);
    checkOutput({tag, "_carry"},  32'(carry),  0);
    checkOutput({tag, "_busy"},   32'(busy),   0);
    checkOutput({tag, "_alu_a"},  32'(aluA),   0);
    checkOutput({tag, "_alu_b"},  32'(aluB),   0);
    checkOutput({tag, "_alu_op"}, 32'(aluOp),  0);
    checkOutput({tag, "_cnt0"},   32'(cnt0),   0);
    checkOutput({tag, "_cnt1"},   32'(cnt1),   0);
  endtask

  // One requester transaction: raise req with operands, hold until done.
  // With lateHold the request is kept through the following IDLE cycle,
  // which the sequencer must treat as a second request with the same data.
  task automatic applyStimulus(input int p, input logic [W-1:0] a,
                               input logic [W-1:0] b, input int gap,
                               input bit lateHold);
    int waited;
    int rounds;
    repeat (gap) @(negedge clk);
    if (p == 0) begin
      opa0 = a; opb0 = b; req0 = 1'b1; qa0.push_back({a, b});
    end else begin
      opa1 = a; opb1 = b; req1 = 1'b1; qa1.push_back({a, b});
    end
    rounds = lateHold ? 2 : 1;
    for (int r = 0; r < rounds; r++) begin
      waited = 0;
      do begin
        @(negedge clk);
        waited++;
      end while (!done[p] && waited < 40);
      if (!done[p]) reportFail($sformatf("done_timeout_port%0d", p));
      if (r == 0 && lateHold) begin
        if (p == 0) qa0.push_back({a, b});
        else        qa1.push_back({a, b});
      end
    end
    if (p == 0) req0 = 1'b0;
    else        req1 = 1'b0;
  endtask

  // Requests as seen at each rising edge (drivers only change on negedge).
  logic [1:0] reqPrev = 2'b00;
  always @(posedge clk) reqPrev = req;

  // Monitor / scoreboard.
  int             cycle      = 0;
  int             prefer     = 0;
  int             pendPort   = 0;
  int             grantCycle = 0;
  int             lastGrant  = -100;
  bit             havePending = 1'b0;
  logic [CNT_W-1:0] expCnt0 = '0;
  logic [CNT_W-1:0] expCnt1 = '0;

  always @(negedge clk) begin
    int w;
    logic [2*W-1:0] e;
    logic [W:0] sum9;
    cycle++;
    if (!rst_n) begin
      prefer      = 0;
      expCnt0     = '0;
      expCnt1     = '0;
      havePending = 1'b0;
      lastGrant   = -100;
      qa0.delete();
      qa1.delete();
    end else begin
      if (gnt != 2'b00) begin
        checkOutput("gnt_has_request", 32'(reqPrev != 2'b00), 1);
        case (reqPrev)
          2'b01:   w = 0;
          2'b10:   w = 1;
          default: w = prefer;
        endcase
        checkOutput("gnt_winner", 32'(gnt), (w == 0) ? 1 : 2);
        if ((w == 0) ? (qa0.size() > 0) : (qa1.size() > 0)) begin
          e = (w == 0) ? qa0[0] : qa1[0];
          checkOutput("alu_a", 32'(aluA), 32'(e[2*W-1:W]));
          checkOutput("alu_b", 32'(aluB), 32'(e[W-1:0]));
        end else begin
          reportFail("gnt_without_queued_request");
        end
        checkOutput("alu_op_exec", 32'(aluOp), 1);
        checkOutput("busy_exec", 32'(busy), 1);
        checkOutput("gnt_spacing", 32'((cycle - lastGrant) >= 3), 1);
        prefer      = 1 - w;
        pendPort    = w;
        grantCycle  = cycle;
        lastGrant   = cycle;
        havePending = 1'b1;
      end
      if (done != 2'b00) begin
        if (!havePending) begin
          reportFail("done_without_grant");
        end else begin
          checkOutput("done_port", 32'(done), (pendPort == 0) ? 1 : 2);
          checkOutput("done_latency", 32'(cycle - grantCycle), 1);
          if ((pendPort == 0) ? (qa0.size() > 0) : (qa1.size() > 0)) begin
            e = (pendPort == 0) ? qa0.pop_front() : qa1.pop_front();
            sum9 = {1'b0, e[2*W-1:W]} + {1'b0, e[W-1:0]};
            checkOutput("result", 32'(result), 32'(sum9[W-1:0]));
            checkOutput("carry", 32'(carry), 32'(sum9[W]));
          end else begin
            reportFail("done_with_empty_queue");
          end
          if (pendPort == 0) expCnt0 = expCnt0 + 1'b1;
          else               expCnt1 = expCnt1 + 1'b1;
          checkOutput("cnt0", 32'(cnt0), 32'(expCnt0));
          checkOutput("cnt1", 32'(cnt1), 32'(expCnt1));
          checkOutput("alu_op_done", 32'(aluOp), 0);
          checkOutput("gnt_in_done", 32'(gnt), 0);
          checkOutput("busy_done", 32'(busy), 1);
          havePending = 1'b0;
        end
      end else if (havePending && cycle > grantCycle + 1) begin
        reportFail("done_missing");
        havePending = 1'b0;
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int waited;
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    opa0 = '0; opb0 = '0; opa1 = '0; opb1 = '0;
    repeat (3) @(negedge clk);
    checkResetOutputs("por");
    #2 rst_n = 1'b1;

    // Single request on port 0.
    applyStimulus(0, 8'h12, 8'h34, 1, 1'b0);
    checkOutput("single_result", 32'(result), 32'h46);
    checkOutput("single_carry", 32'(carry), 0);
    checkOutput("single_cnt0", 32'(cnt0), 1);

    // Carry and wrap cases on port 1.
    applyStimulus(1, 8'hF0, 8'h20, 1, 1'b0);
    checkOutput("wrap1_result", 32'(result), 32'h10);
    checkOutput("wrap1_carry", 32'(carry), 1);
    applyStimulus(1, 8'h80, 8'h80, 1, 1'b0);
    checkOutput("wrap2_result", 32'(result), 32'h00);
    checkOutput("wrap2_carry", 32'(carry), 1);
    applyStimulus(1, 8'h7F, 8'h01, 1, 1'b0);
    checkOutput("wrap3_result", 32'(result), 32'h80);
    checkOutput("wrap3_carry", 32'(carry), 0);
    checkOutput("wrap_cnt1", 32'(cnt1), 3);

    // Late release: request held into IDLE becomes a second operation.
    applyStimulus(0, 8'h55, 8'hAA, 1, 1'b1);
    checkOutput("late_result", 32'(result), 32'hFF);
    checkOutput("late_cnt0", 32'(cnt0), 3);

    // Contention: both ports re-request right after each done.
    fork
      for (int i = 0; i < 4; i++)
        applyStimulus(0, W'($urandom), W'($urandom), 1, 1'b0);
      for (int i = 0; i < 4; i++)
        applyStimulus(1, W'($urandom), W'($urandom), 1, 1'b0);
    join
    checkOutput("contention_cnt0", 32'(cnt0), 7);
    checkOutput("contention_cnt1", 32'(cnt1), 7);

    // Reset in the middle of EXEC with both ports requesting.
    @(negedge clk);
    opa0 = 8'h11; opb0 = 8'h22; req0 = 1'b1; qa0.push_back({8'h11, 8'h22});
    opa1 = 8'h33; opb1 = 8'h44; req1 = 1'b1; qa1.push_back({8'h33, 8'h44});
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (gnt == 2'b00 && waited < 10);
    if (gnt == 2'b00) reportFail("reset_test_no_grant");
    rst_n = 1'b0;
    #1 checkResetOutputs("rst_exec");
    repeat (2) @(negedge clk);
    checkResetOutputs("rst_hold");
    #2 rst_n = 1'b1;
    fork
      applyStimulus(0, 8'h11, 8'h22, 0, 1'b0);
      applyStimulus(1, 8'h33, 8'h44, 0, 1'b0);
    join
    checkOutput("post_reset_cnt0", 32'(cnt0), 1);
    checkOutput("post_reset_cnt1", 32'(cnt1), 1);

    // Counter wrap: 16 operations on port 0 return cnt0 to zero.
    @(negedge clk);
    rst_n = 1'b0;
    #1 checkResetOutputs("rst_wrap");
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 16; i++)
      applyStimulus(0, W'($urandom), W'($urandom), 1, 1'b0);
    checkOutput("cntwrap_cnt0", 32'(cnt0), 0);
    checkOutput("cntwrap_cnt1", 32'(cnt1), 0);

    // Randomised traffic from both ports.
    fork
      for (int i = 0; i < 25; i++)
        applyStimulus(0, W'($urandom), W'($urandom), $urandom_range(0, 3),
                      ($urandom_range(0, 3) == 0));
      for (int i = 0; i < 25; i++)
        applyStimulus(1, W'($urandom), W'($urandom), $urandom_range(0, 3),
                      ($urandom_range(0, 3) == 0));
    join

    repeat (4) @(negedge clk);
    checkOutput("queue0_drained", 32'(qa0.size()), 0);
    checkOutput("queue1_drained", 32'(qa1.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
